// File: rtl/intlv_pkg.sv
// Shared types for the ping-pong block interleaver.
// Bank state encoding and per-frame mode constants.
package intlv_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  localparam logic INTLV_MODE_INTERLEAVE   = 1'b0;
  localparam logic INTLV_MODE_DEINTERLEAVE = 1'b1;

  function automatic int intlv_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Outer/inner read counters for the block interleaver.
// Produces the permuted bank address and the end-of-frame flag.
module intlv_addr_gen
  import intlv_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 4,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          mode,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] R_ST = AW'(ROWS);
  localparam logic [AW-1:0] C_ST = AW'(COLS);
  localparam logic [AW-1:0] R_MX = AW'(ROWS - 1);
  localparam logic [AW-1:0] C_MX = AW'(COLS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [AW-1:0] outer;
  logic [AW-1:0] inner;
  logic [AW-1:0] outer_max;
  logic [AW-1:0] inner_max;
  logic [AW-1:0] stride;

  // Both modes reduce to inner*stride + outer.
  always_comb begin
    outer_max = R_MX;
    inner_max = C_MX;
    stride    = R_ST;
    if (mode == INTLV_MODE_DEINTERLEAVE) begin
      outer_max = C_MX;
      inner_max = R_MX;
      stride    = C_ST;
    end
  end

  assign addr = inner * stride + outer;
  assign last = (outer == outer_max) &&
                (inner == inner_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outer <= '0;
      inner <= '0;
    end else if (step) begin
      if (inner == inner_max) begin
        inner <= '0;
        if (outer == outer_max) outer <= '0;
        else outer <= outer + ONE;
      end else begin
        inner <= inner + ONE;
      end
    end
  end

endmodule

// File: rtl/block_interleaver_pp.sv
// Streaming ping-pong block interleaver/deinterleaver.
// Define INTLV_FLUSH_EN to add the flush port (zero-pads partial frames).
module block_interleaver_pp
  import intlv_pkg::*;
#(
  parameter int ROWS  = 7,
  parameter int COLS  = 4,
  parameter int SYM_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
`ifdef INTLV_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_last
);

  localparam int N  = ROWS * COLS;
  localparam int AW = intlv_aw(N);
  localparam logic [AW-1:0] LAST_K = AW'(N - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);

  logic [SYM_W-1:0] mem [2][N];
  bank_state_t      st [2];
  bank_state_t      st_nxt [2];
  logic             bank_mode [2];

  logic             wr_ptr;
  logic             rd_ptr;
  logic [AW-1:0]    wr_cnt;
  logic             pad;
  logic             wr_open;
  logic             acc;
  logic             wr_en;
  logic             wr_end;
  logic             early;
  logic             rd_avail;
  logic             load;
  logic             rd_last;
  logic [AW-1:0]    rd_addr;
  logic [SYM_W-1:0] wr_data;
  logic [SYM_W-1:0] rd_data;

  assign wr_open  = (st[wr_ptr] == EMPTY) ||
                    (st[wr_ptr] == FILLING);
  assign in_ready = !rst && wr_open && !pad;
  assign acc      = in_valid && in_ready;
  assign wr_en    = acc || pad;
  assign wr_data  = pad ? '0 : in_data;
  assign wr_end   = wr_en && (wr_cnt == LAST_K);

  // Final write into the bank the reader is waiting on:
  // start draining in the same cycle to save a bubble.
  assign early    = wr_end && (wr_ptr == rd_ptr);
  assign rd_avail = (st[rd_ptr] == FULL) ||
                    (st[rd_ptr] == DRAINING) ||
                    early;
  assign load     = (!out_valid || out_ready) && rd_avail;

  assign rd_data  = (early && (rd_addr == wr_cnt)) ?
                    wr_data : mem[rd_ptr][rd_addr];

  intlv_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .step (load),
    .mode (bank_mode[rd_ptr]),
    .addr (rd_addr),
    .last (rd_last)
  );

`ifdef INTLV_FLUSH_EN
  logic pad_start;

  assign pad_start = flush && !pad &&
                     (st[wr_ptr] == FILLING) &&
                     !(acc && (wr_cnt == LAST_K));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad <= 1'b0;
    end else if (pad_start) begin
      pad <= 1'b1;
    end else if (pad && (wr_cnt == LAST_K)) begin
      pad <= 1'b0;
    end
  end
`else
  assign pad = 1'b0;
`endif

  always_comb begin
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    if (wr_en) begin
      st_nxt[wr_ptr] = wr_end ? FULL : FILLING;
    end
    if (load) begin
      st_nxt[rd_ptr] = rd_last ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr][wr_cnt] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0]        <= EMPTY;
      st[1]        <= EMPTY;
      bank_mode[0] <= INTLV_MODE_INTERLEAVE;
      bank_mode[1] <= INTLV_MODE_INTERLEAVE;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_cnt       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else begin
      st[0] <= st_nxt[0];
      st[1] <= st_nxt[1];
      if (wr_en) begin
        if (wr_cnt == '0) bank_mode[wr_ptr] <= mode;
        if (wr_end) begin
          wr_cnt <= '0;
          wr_ptr <= !wr_ptr;
        end else begin
          wr_cnt <= wr_cnt + ONE;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_last  <= rd_last;
        if (rd_last) rd_ptr <= !rd_ptr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_interleaver_pp.sv
// Self-checking bench for block_interleaver_pp (default build).
// Directed steps with random frames against a permutation model.
module tb_block_interleaver_pp;

  localparam int ROWS  = 7;
  localparam int COLS  = 4;
  localparam int SYM_W = 5;
  localparam int N     = ROWS * COLS;

  typedef logic [SYM_W-1:0] sym_t;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic mode      = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  sym_t in_data   = '0;
  logic in_ready;
  logic out_valid;
  logic out_last;
  sym_t out_data;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int stalls = 0;

  sym_t cap_d[$];
  logic cap_l[$];
  int   cap_t[$];

  sym_t f0[N], f1[N], f2[N], f3[N];
  sym_t g0[N], g1[N], g2[N], rmp[N];

  block_interleaver_pp #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .SYM_W (SYM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
      cap_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fail_now(input string tag,
                          input int got, input int exp);
    total++;
    bad++;
    $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // out[b*COLS+a] = in[a*ROWS+b] (interleave), transpose otherwise
  function automatic void permute(input sym_t src[N],
                                  input logic m,
                                  output sym_t dst[N]);
    for (int a = 0; a < COLS; a++)
      for (int b = 0; b < ROWS; b++)
        if (m == 1'b0) dst[b*COLS+a] = src[a*ROWS+b];
        else dst[a*ROWS+b] = src[b*COLS+a];
  endfunction

  task automatic rand_frame(output sym_t f[N]);
    for (int k = 0; k < N; k++) f[k] = sym_t'($urandom);
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    cap_t.delete();
  endtask

  task automatic push(input sym_t d, input logic m);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (w > 0) stalls++;
    if (!in_ready) fail_now("push_timeout", w, 0);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input sym_t f[N], input logic m);
    for (int k = 0; k < N; k++) push(f[k], m);
  endtask

  task automatic wait_out(input int n, input string tag);
    int w;
    w = 0;
    while (cap_d.size() < n && w < 400) begin
      @(posedge clk);
      w++;
    end
    if (cap_d.size() < n) fail_now(tag, cap_d.size(), n);
    #1;
  endtask

  task automatic check_frame(input string tag,
                             input sym_t src[N],
                             input logic m,
                             input int base);
    sym_t e[N];
    permute(src, m, e);
    for (int j = 0; j < N; j++) begin
      if (base + j < cap_d.size()) begin
        chk($sformatf("%s_d%0d", tag, j),
            cap_d[base+j], e[j]);
        chk($sformatf("%s_l%0d", tag, j),
            cap_l[base+j], (j == N - 1));
      end
    end
  endtask

  function automatic int gaps(input int lo, input int hi);
    int g;
    g = 0;
    for (int j = lo; j + 1 < hi && j + 1 < cap_t.size(); j++)
      if (cap_t[j+1] != cap_t[j] + 1) g++;
    return g;
  endfunction

  initial begin
    int   acc;
    int   idle;
    int   w;
    int   n;
    logic ir_prev;
    logic m0, m1, m3;
    sym_t e[N];

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // ramp, interleave
    for (int k = 0; k < N; k++) rmp[k] = sym_t'(k);
    out_ready = 1'b1;
    clear_cap();
    send_frame(rmp, 1'b0);
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_data", out_data, 0);
    wait_out(N, "t1_timeout");
    check_frame("t1", rmp, 1'b0, 0);
    if (cap_d.size() >= N) begin
      chk("t1_e1", cap_d[1], 7);
      chk("t1_e4", cap_d[4], 1);
      chk("t1_e27", cap_d[N-1], 27);
    end

    // ramp, deinterleave
    repeat (3) @(posedge clk);
    #1;
    clear_cap();
    send_frame(rmp, 1'b1);
    chk("t2_lat_valid", out_valid, 1);
    wait_out(N, "t2_timeout");
    check_frame("t2", rmp, 1'b1, 0);
    if (cap_d.size() >= N) begin
      chk("t2_e1", cap_d[1], 4);
      chk("t2_e7", cap_d[7], 1);
      chk("t2_e27", cap_d[N-1], 27);
    end

    // round trip, back-to-back frames
    repeat (3) @(posedge clk);
    #1;
    clear_cap();
    rand_frame(f0);
    rand_frame(f1);
    rand_frame(f2);
    stalls = 0;
    send_frame(f0, 1'b0);
    send_frame(f1, 1'b0);
    send_frame(f2, 1'b0);
    chk("t3a_stalls", stalls, 0);
    wait_out(3 * N, "t3a_timeout");
    check_frame("t3a_f0", f0, 1'b0, 0);
    check_frame("t3a_f1", f1, 1'b0, N);
    check_frame("t3a_f2", f2, 1'b0, 2 * N);
    chk("t3a_gaps", gaps(0, 3 * N), 0);
    if (cap_d.size() >= 3 * N) begin
      for (int j = 0; j < N; j++) begin
        g0[j] = cap_d[j];
        g1[j] = cap_d[N+j];
        g2[j] = cap_d[2*N+j];
      end
    end
    clear_cap();
    stalls = 0;
    send_frame(g0, 1'b1);
    send_frame(g1, 1'b1);
    send_frame(g2, 1'b1);
    chk("t3b_stalls", stalls, 0);
    wait_out(3 * N, "t3b_timeout");
    if (cap_d.size() >= 3 * N) begin
      for (int j = 0; j < N; j++) begin
        chk($sformatf("rt_f0_%0d", j), cap_d[j], f0[j]);
        chk($sformatf("rt_f1_%0d", j), cap_d[N+j], f1[j]);
        chk($sformatf("rt_f2_%0d", j), cap_d[2*N+j], f2[j]);
      end
    end
    chk("t3b_gaps", gaps(0, 3 * N), 0);

    // backpressure: both banks fill, then drain
    repeat (3) @(posedge clk);
    #1;
    clear_cap();
    out_ready = 1'b0;
    acc  = 0;
    idle = 0;
    for (int c = 0; c < 90 && idle < 6; c++) begin
      in_valid = 1'b1;
      in_data  = sym_t'($urandom);
      if (acc < N) mode = (acc >= 5 && acc < 10);
      else mode = !(acc >= N + 3 && acc < N + 8);
      if (in_ready) begin
        if (acc < N) g0[acc] = in_data;
        else if (acc < 2 * N) g1[acc-N] = in_data;
        acc++;
        idle = 0;
      end else begin
        idle++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t4_accepted", acc, 2 * N);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_no_handshake", cap_d.size(), 0);
    chk("t4_hold_valid", out_valid, 1);
    chk("t4_hold_data", out_data, g0[0]);
    out_ready = 1'b1;
    w = 0;
    @(negedge clk);
    ir_prev = in_ready;
    while (!(out_valid && out_last) && w < 200) begin
      ir_prev = in_ready;
      @(negedge clk);
      w++;
    end
    if (w >= 200) fail_now("t4_last_timeout", w, 0);
    chk("t4_ir_before_last", ir_prev, 0);
    chk("t4_ir_after_last", in_ready, 1);
    wait_out(2 * N, "t4_timeout");
    check_frame("t4_f0", g0, 1'b0, 0);
    check_frame("t4_f1", g1, 1'b1, N);

    // reset mid-operation
    repeat (3) @(posedge clk);
    #1;
    clear_cap();
    rand_frame(f0);
    rand_frame(f1);
    rand_frame(f2);
    m0 = 1'($urandom_range(0, 1));
    m1 = 1'($urandom_range(0, 1));
    send_frame(f0, m0);
    send_frame(f1, m1);
    for (int k = 0; k < 13; k++) push(f2[k], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    n = cap_d.size();
    chk("t5_f1_started", (n > N && n < 2 * N), 1);
    check_frame("t5_f0", f0, m0, 0);
    permute(f1, m1, e);
    for (int j = 0; N + j < n && j < N; j++)
      chk($sformatf("t5_f1_%0d", j), cap_d[N+j], e[j]);
    repeat (2) @(posedge clk);
    #1;
    clear_cap();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_stale", cap_d.size(), 0);
    chk("t5_idle_valid", out_valid, 0);
    rand_frame(f3);
    m3 = 1'($urandom_range(0, 1));
    send_frame(f3, m3);
    wait_out(N, "t5_timeout");
    check_frame("t5_f3", f3, m3, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_exact_count", cap_d.size(), N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
